round_controller: RTL

- Game sequencer that sits directly upstream and downstream of the answer-check stage.
- Each round it picks a one-hot target button and drives it as `randomnumber`, then runs the per-round countdown and drives `timerdone`.
- It consumes the registered `correct` verdict and tallies the score and round count until the game ends.

---
 rtl/round_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Game sequencer wrapped around the answer-check stage. Each round it
// loads a one-hot target button (never repeating the previous one), runs a
// per-round countdown and waits for the checker's registered verdict. It
// tallies hits and rounds until the game ends.
//
// Ports
//   clock        system clock, all state changes on posedge
//   reset        asynchronous active-high reset (returns to IDLE)
//   start        begins / restarts a game from IDLE or DONE
//   correct      registered match verdict from the checker
//   randomnumber current one-hot target button (registered)
//   timerdone    one-cycle pulse, high during the cycle after a round timeout
//   score        hits this game, saturating
//   round_num    0-based index of the current round
//   busy         high in LOAD, PLAY, HIT and MISS
//   game_over    high in DONE
//   lives        (ROUND_LIVES_EN only) remaining misses before the game ends
//
// Optional feature macro: ROUND_LIVES_EN
//   When defined, a `lives` counter (reload 3 on every game start) is
//   decremented on each MISS; the MISS that empties it ends the game.
// -----------------------------------------------------------------------------
module round_controller #(
    parameter int TICKS_PER_ROUND = 50000000,
    parameter int ROUNDS          = 10,
    parameter int SCORE_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               correct,
    output logic [3:0]         randomnumber,
    output logic               timerdone,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         round_num,
    output logic               busy,
    output logic               game_over
`ifdef ROUND_LIVES_EN
    ,
    output logic [1:0]         lives
`endif
);

    localparam int             TW         = (TICKS_PER_ROUND > 1) ? $clog2(TICKS_PER_ROUND) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TICKS_PER_ROUND - 1);
    localparam logic [3:0]     LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_HIT  = 3'd3,
        S_MISS = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [7:0]         lfsr_reg;
    logic [TW-1:0]      timer_reg;
    logic               blank_reg;
    logic [3:0]         randomnumber_reg;
    logic               timerdone_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [3:0]         round_num_reg;

    logic               lfsr_fb;
    logic [3:0]         cand_raw;
    logic [3:0]         cand;
    logic               hit_now;
    logic               timeout_now;
    logic               last_round;
    logic               out_of_lives;
    logic               game_start;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB. The all-zero
    // state is unreachable from the non-zero seed.
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    // One-hot decode of the two LFSR LSBs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand_raw[gi] = (lfsr_reg[1:0] == 2'(gi));
    end

    // Rotate away from the current target so a round never repeats it.
    assign cand = (cand_raw == randomnumber_reg) ? {cand_raw[2:0], cand_raw[3]} : cand_raw;

    // The first PLAY cycle is blanked: the checker's verdict there still
    // refers to the previous target.
    assign hit_now     = (state_reg == S_PLAY) && !blank_reg && correct;
    assign timeout_now = (state_reg == S_PLAY) && !hit_now && (timer_reg == '0);
    assign last_round  = (round_num_reg == LAST_ROUND);
    assign game_start  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

`ifdef ROUND_LIVES_EN
    logic [1:0] lives_reg;
    assign out_of_lives = (lives_reg == 2'd1);
    assign lives        = lives_reg;
`else
    assign out_of_lives = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_PLAY;
            S_PLAY: begin
                if (hit_now) begin
                    state_next = S_HIT;
                end else if (timeout_now) begin
                    state_next = S_MISS;
                end
            end
            S_HIT:  state_next = last_round ? S_DONE : S_LOAD;
            S_MISS: state_next = (last_round || out_of_lives) ? S_DONE : S_LOAD;
            S_DONE: if (start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = 1'b0;
        game_over = 1'b0;
        case (state_reg)
            S_LOAD, S_PLAY, S_HIT, S_MISS: busy = 1'b1;
            S_DONE:                        game_over = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_reg         <= 8'hA5;
            timer_reg        <= '0;
            blank_reg        <= 1'b0;
            randomnumber_reg <= 4'b0001;
            timerdone_reg    <= 1'b0;
            score_reg        <= '0;
            round_num_reg    <= '0;
`ifdef ROUND_LIVES_EN
            lives_reg        <= 2'd3;
`endif
        end else begin
            lfsr_reg      <= {lfsr_reg[6:0], lfsr_fb};
            timerdone_reg <= timeout_now;

            if (game_start) begin
                score_reg     <= '0;
                round_num_reg <= '0;
`ifdef ROUND_LIVES_EN
                lives_reg     <= 2'd3;
`endif
            end

            case (state_reg)
                S_LOAD: begin
                    randomnumber_reg <= cand;
                    timer_reg        <= TIMER_LOAD;
                    blank_reg        <= 1'b1;
                end
                S_PLAY: begin
                    blank_reg <= 1'b0;
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                S_HIT: begin
                    if (score_reg != '1) begin
                        score_reg <= score_reg + SCORE_W'(1);
                    end
                    if (state_next == S_LOAD) begin
                        round_num_reg <= round_num_reg + 4'd1;
                    end
                end
                S_MISS: begin
`ifdef ROUND_LIVES_EN
                    lives_reg <= lives_reg - 2'd1;
`endif
                    if (state_next == S_LOAD) begin
                        round_num_reg <= round_num_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign randomnumber = randomnumber_reg;
    assign timerdone    = timerdone_reg;
    assign score        = score_reg;
    assign round_num    = round_num_reg;

endmodule
